// File: rtl/adc_fifo_ctrl_pkg.sv
// adc_fifo_ctrl_pkg: shared state encoding, FIFO flag constants and Fifo_Din field layout
// Exports: state_t, FLAG_FULL, FLAG_EMPTY, DIN_* field positions, pack_din()
package adc_fifo_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;
    localparam logic [3:0] FLAG_FULL   = 4'h0;
    localparam logic [3:0] FLAG_EMPTY  = 4'h0;
    localparam int         DIN_W       = 18;
    localparam int         DIN_GAP     = 17;
    localparam int         DIN_CHAN_HI = 16;
    localparam int         DIN_CHAN_LO = 15;
    localparam int         DIN_DATA_HI = 11;
    localparam int         DIN_DATA_LO = 0;
    function automatic logic [DIN_W-1:0] pack_din(input logic gap, input logic [1:0] chan, input logic [11:0] data);
        pack_din = '0;
        pack_din[DIN_GAP] = gap;
        pack_din[DIN_CHAN_HI:DIN_CHAN_LO] = chan;
        pack_din[DIN_DATA_HI:DIN_DATA_LO] = data;
    endfunction
endpackage

// File: rtl/adc_fifo_ctrl_if.sv
// adc_fifo_if: FIFO0 port bundle between the capture controller (master) and the FIFO (slave)
// Signals: push/pop strobes, fifo_din write data, push/pop flush lines, push_flag/pop_flag levels, fifo_dout read data
interface adc_fifo_if;
    logic        push;
    logic        pop;
    logic [17:0] fifo_din;
    logic        fifo_push_flush;
    logic        fifo_pop_flush;
    logic [3:0]  push_flag;
    logic [3:0]  pop_flag;
    logic [17:0] fifo_dout;
    modport master (
        output push, pop, fifo_din, fifo_push_flush, fifo_pop_flush,
        input  push_flag, pop_flag, fifo_dout
    );
    modport slave (
        input  push, pop, fifo_din, fifo_push_flush, fifo_pop_flush,
        output push_flag, pop_flag, fifo_dout
    );
endinterface

// File: rtl/adc_fifo_ctrl_flush_seq.sv
// adc_fifo_flush_seq: holds both FIFO flush lines for FLUSH_CYCLES cycles after start
// Ports: clk, rst_n (async active-low), start (flush entry pulse), flush_push/flush_pop (flush lines), done (last flush cycle)
module adc_fifo_flush_seq
    import adc_fifo_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic flush_push,
    output logic flush_pop,
    output logic done
);
    logic [3:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= start ? 4'(FLUSH_CYCLES) : (cnt_q != 4'd0 ? cnt_q - 4'd1 : 4'd0);
    assign flush_push = cnt_q != 4'd0;
    assign flush_pop  = cnt_q != 4'd0;
    assign done       = cnt_q == 4'd1;
endmodule

// File: rtl/adc_fifo_ctrl.sv
// adc_fifo_ctrl: ADC sample capture into FIFO0 with host pop path, overflow tracking and flush sequencing
// Ports: clk, rst_n (async active-low); enable, flush_req; smp_valid/smp_data/smp_chan sample input;
//        fifo (adc_fifo_if.master) FIFO0 port; rd_req in, rd_data/rd_valid out; ovf_clr in, ovf_sticky out;
//        wm_irq watermark level; state FSM state; ovf_cnt dropped-sample count when ADC_FIFO_CTRL_OVF_CNT_EN is defined
module adc_fifo_ctrl
    import adc_fifo_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 4,
    parameter logic [3:0]  WM_FLAG      = 4'h8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    input  logic           flush_req,
    input  logic           smp_valid,
    input  logic [11:0]    smp_data,
    input  logic [1:0]     smp_chan,
    adc_fifo_if.master     fifo,
    input  logic           rd_req,
    output logic [17:0]    rd_data,
    output logic           rd_valid,
    input  logic           ovf_clr,
    output logic           ovf_sticky,
    output logic           wm_irq,
`ifdef ADC_FIFO_CTRL_OVF_CNT_EN
    output logic [15:0]    ovf_cnt,
`endif
    output logic [1:0]     state
);
    state_t      state_q, state_d;
    logic        gap_q, push_q, pop_q;
    logic [17:0] din_q;
    logic        flush_start, flush_done, accept, drop, pop_go;
    logic        flush_push, flush_pop;
    always_comb begin
        state_d     = ST_IDLE;
        flush_start = 1'b0;
        accept      = 1'b0;
        drop        = 1'b0;
        pop_go      = 1'b0;
        // a Flush_Req during FLUSH is ignored so the count is never restarted
        flush_start = flush_req && state_q != ST_FLUSH;
        accept      = state_q == ST_RUN && smp_valid && !flush_req && fifo.push_flag != FLAG_FULL;
        drop        = state_q == ST_RUN && smp_valid && !flush_req && fifo.push_flag == FLAG_FULL;
        pop_go      = rd_req && fifo.pop_flag != FLAG_EMPTY && !pop_q && state_q != ST_FLUSH && !flush_req;
        state_d     = flush_start ? ST_FLUSH :
                      state_q == ST_FLUSH ? (flush_done ? ST_IDLE : ST_FLUSH) :
                      (state_q == ST_IDLE || state_q == ST_RUN) && enable ? ST_RUN : ST_IDLE;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gap_q      <= 1'b0;
            push_q     <= 1'b0;
            din_q      <= '0;
            pop_q      <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            ovf_sticky <= 1'b0;
            wm_irq     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= (flush_start || accept) ? 1'b0 : (drop ? 1'b1 : gap_q);
            push_q     <= accept;
            if (accept) din_q <= pack_din(gap_q, smp_chan, smp_data);
            pop_q      <= pop_go;
            // a read whose pop cycle meets a flush request is discarded
            rd_valid   <= pop_q && !flush_req;
            if (pop_q) rd_data <= fifo.fifo_dout;
            ovf_sticky <= drop || (ovf_sticky && !ovf_clr);
            wm_irq     <= state_q == ST_RUN && fifo.pop_flag >= WM_FLAG;
        end
`ifdef ADC_FIFO_CTRL_OVF_CNT_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ovf_cnt <= '0;
        else        ovf_cnt <= (ovf_clr || flush_start) ? {15'd0, drop} :
                               (drop && ovf_cnt != 16'hFFFF) ? ovf_cnt + 16'd1 : ovf_cnt;
`endif
    adc_fifo_flush_seq #(.FLUSH_CYCLES(FLUSH_CYCLES)) u_flush_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (flush_start),
        .flush_push (flush_push),
        .flush_pop  (flush_pop),
        .done       (flush_done)
    );
    assign fifo.push            = push_q;
    assign fifo.pop             = pop_q;
    assign fifo.fifo_din        = din_q;
    assign fifo.fifo_push_flush = flush_push;
    assign fifo.fifo_pop_flush  = flush_pop;
    assign state                = state_q;
endmodule

// File: doc/adc_fifo_ctrl.md
ADC_FIFO_CTRL -- requirements
Module: adc_fifo_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 4: cycles the flush lines are held asserted (range 1..15).
REQ-002 Parameter WM_FLAG, default 4'h8: Pop_Flag level at or above which Wm_Irq asserts.
REQ-003 Clk  in  1  single clock for the block and both FIFO ports; reset is asynchronous and active-low.
REQ-004 Rst_n  in  1  asynchronous active-low reset.
REQ-005 Enable  in  1  level; 1 = capture running.
REQ-006 Flush_Req  in  1  one-cycle pulse requesting a FIFO flush.
REQ-007 Smp_Valid / Smp_Data / Smp_Chan  in  1/12/2  ADC sample strobe, data and channel tag.
REQ-008 Push_Flag / Pop_Flag  in  4/4  FIFO0 flags; Push_Flag==0 means full, Pop_Flag==0 means empty.
REQ-009 Fifo_Dout  in  18  FIFO0 read data.
REQ-010 Push / Pop  out  1/1  FIFO0 push and pop strobes.
REQ-011 Fifo_Din  out  18  FIFO0 write data.
REQ-012 Fifo_Push_Flush / Fifo_Pop_Flush  out  1/1  FIFO0 flush lines.
REQ-013 Rd_Req  in  1  host pop request pulse; Rd_Data / Rd_Valid  out  18/1  popped word and its strobe.
REQ-014 Ovf_Clr  in  1  clears Ovf_Sticky; Ovf_Sticky  out  1  sample-dropped flag.
REQ-015 Wm_Irq  out  1  watermark interrupt; State  out  2  FSM state.

Function
REQ-016 The FSM has states IDLE=0, RUN=1 and FLUSH=2; encoding 3 is unreachable and returns to IDLE.
- IDLE->RUN on Enable=1.
- RUN->IDLE on Enable=0.
- Any state->FLUSH on Flush_Req.
- FLUSH->IDLE after FLUSH_CYCLES cycles.
REQ-017 In FLUSH, Fifo_Push_Flush and Fifo_Pop_Flush are both 1, and Push and Pop are both 0.
- The sample gap marker, the in-flight read and any Flush_Req repeated during FLUSH are discarded; a repeated Flush_Req does not restart the count.
REQ-018 Push path, evaluated in RUN on a Smp_Valid cycle:
- If Push_Flag!=0, the next cycle drives Push=1 and Fifo_Din={gap,Smp_Chan,3'b000,Smp_Data}.
- If Push_Flag==0, the sample is dropped, Ovf_Sticky is set and gap is set.
- gap clears on the next accepted push.
REQ-019 Push is a single-cycle, 1-cycle-latency registered strobe; Smp_Valid outside RUN is ignored.
REQ-020 Pop path:
- Rd_Req with Pop_Flag!=0 and no read in flight drives Pop=1 on the next cycle.
- Fifo_Dout is registered into Rd_Data with Rd_Valid=1 one cycle after Pop, i.e. 2 cycles after Rd_Req.
REQ-021 Rd_Req on empty, or while a read is in flight, is ignored.
- Pop is independent of Enable, so the host can drain the FIFO in IDLE.
REQ-022 Flush_Req has priority over push and pop in the same cycle.
REQ-023 A new overflow in the same cycle as Ovf_Clr leaves Ovf_Sticky=1.
REQ-024 Wm_Irq is a registered level: 1 when Pop_Flag>=WM_FLAG in RUN, else 0.
REQ-025 Enable falling while a push is pending still completes that push.

Reset
REQ-026 Asserting Rst_n low immediately forces all outputs to 0, State=IDLE, gap=0 and the flush counter to 0, including mid-push, mid-pop and mid-flush.
REQ-027 After reset release, the first possible Push occurs 2 cycles after Enable rises (Enable sampled, then Smp_Valid registered).

Configuration
REQ-028 With ADC_FIFO_CTRL_OVF_CNT_EN defined:
- An additional 16-bit output Ovf_Cnt counts dropped samples, saturating at 16'hFFFF.
- Ovf_Cnt clears on Ovf_Clr or on entry to FLUSH.
REQ-029 Without ADC_FIFO_CTRL_OVF_CNT_EN, the Ovf_Cnt port and counter are absent and all other behaviour is unchanged.

Structure
REQ-030 Shared package adc_fifo_ctrl_pkg holds:
- the state encoding;
- the FIFO flag constants FLAG_FULL=4'h0 and FLAG_EMPTY=4'h0;
- the Fifo_Din field positions (gap=17, chan=16:15, data=11:0).
REQ-031 A single sub-module, adc_fifo_flush_seq, owns the FLUSH_CYCLES counter and the flush line outputs; everything else is flat.

Verification
REQ-032 Reset, Enable=1, then Smp_Valid with Smp_Data=12'hABC, Smp_Chan=2 and Push_Flag=4'h5 -> Push=1 one cycle later with Fifo_Din=18'h10ABC.
REQ-033 Push_Flag=0 with two Smp_Valid, then Push_Flag=4'h3 with Smp_Data=12'h001, Smp_Chan=0 -> no Push for the first two, Ovf_Sticky=1, Fifo_Din=18'h20001, Ovf_Cnt=2 (macro on).
REQ-034 Rd_Req with Pop_Flag=4'h2 and Fifo_Dout=18'h3FFFF -> Pop at +1, Rd_Valid=1 with Rd_Data=18'h3FFFF at +2; a second Rd_Req at +1 is ignored.
REQ-035 Flush_Req coinciding with Smp_Valid and Rd_Req -> both flush lines high for exactly 4 cycles, no Push or Pop, State=2 then 0.
REQ-036 Ovf_Clr in the same cycle as a dropped sample -> Ovf_Sticky remains 1.
REQ-037 Rst_n pulsed low mid-flush -> all outputs are 0 asynchronously and State=0.
